// File: rtl/axi4lite_pkg.sv
// Shared definitions for the AXI4-Lite register adapter.
//   resp_t          : AXI response codes (OKAY, SLVERR)
//   adapter_state_e : transaction sequencing states
//   resp_enc()      : maps an error flag onto a response code of the given width
package axi4lite_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10
    } resp_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } adapter_state_e;

    // A 1-bit response channel cannot carry 2'b10, so SLVERR collapses to 1'b1.
    function automatic logic [1:0] resp_enc(input logic err, input int resp_width);
        if (!err) begin
            return RESP_OKAY;
        end
        if (resp_width >= 2) begin
            return RESP_SLVERR;
        end
        return 2'b01;
    endfunction

endpackage

// File: rtl/axi4lite_reg_adapter.sv
// AXI4-Lite slave front end of the timer regblock. Each AXI read or write
// becomes exactly one request on a simple req/ready register bus; the AXI
// response is returned once the register access completes or times out.
// Only one transaction is in flight at a time.
//
// Ports
//   clk_i, rst_i          clock, asynchronous active-high reset
//   s_axi_aw*/w*/b*       AXI4-Lite write address / data / response channels
//   s_axi_ar*/r*          AXI4-Lite read address / data channels
//   reg_req_o, reg_we_o   register access request (held until ready), write flag
//   reg_addr_o            word address = AXI addr[REG_AW+LSB-1:LSB]
//   reg_wdata_o/wstrb_o   write data and byte strobes (forwarded unchanged)
//   reg_rdata_i           read data, sampled with reg_ready_i
//   reg_ready_i/err_i     access complete / access error
module axi4lite_reg_adapter
    import axi4lite_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int RESP_WIDTH  = 1,
    parameter int REG_AW      = 6,
    parameter int ACC_TIMEOUT = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_i,

    input  logic                      s_axi_awvalid_i,
    output logic                      s_axi_awready_o,
    input  logic [ADDR_WIDTH-1:0]     s_axi_awaddr_i,
    input  logic                      s_axi_wvalid_i,
    output logic                      s_axi_wready_o,
    input  logic [DATA_WIDTH-1:0]     s_axi_wdata_i,
    input  logic [DATA_WIDTH/8-1:0]   s_axi_wstrb_i,
    output logic                      s_axi_bvalid_o,
    input  logic                      s_axi_bready_i,
    output logic [RESP_WIDTH-1:0]     s_axi_bresp_o,
    input  logic                      s_axi_arvalid_i,
    output logic                      s_axi_arready_o,
    input  logic [ADDR_WIDTH-1:0]     s_axi_araddr_i,
    output logic                      s_axi_rvalid_o,
    input  logic                      s_axi_rready_i,
    output logic [DATA_WIDTH-1:0]     s_axi_rdata_o,
    output logic [RESP_WIDTH-1:0]     s_axi_rresp_o,

    output logic                      reg_req_o,
    output logic                      reg_we_o,
    output logic [REG_AW-1:0]         reg_addr_o,
    output logic [DATA_WIDTH-1:0]     reg_wdata_o,
    output logic [DATA_WIDTH/8-1:0]   reg_wstrb_o,
    input  logic [DATA_WIDTH-1:0]     reg_rdata_i,
    input  logic                      reg_ready_i,
    input  logic                      reg_err_i
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int LSB        = $clog2(STRB_WIDTH);
    localparam int TW         = $clog2(ACC_TIMEOUT + 1);
    // Loaded on entry to ACCESS so the request stays up for exactly ACC_TIMEOUT cycles.
    localparam logic [TW-1:0] TMO_LOAD = TW'(ACC_TIMEOUT - 1);

    adapter_state_e            state_q, state_d;
    logic                      aw_held_q, aw_held_d;
    logic                      w_held_q, w_held_d;
    logic                      prio_rd_q, prio_rd_d;
    logic                      is_wr_q, is_wr_d;
    logic [REG_AW-1:0]         addr_q, addr_d;
    logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0]     wstrb_q, wstrb_d;
    logic [DATA_WIDTH-1:0]     rdata_q, rdata_d;
    logic [RESP_WIDTH-1:0]     resp_q, resp_d;
    logic [TW-1:0]             tmo_q, tmo_d;
    logic                      rd_grant;
    logic                      resp_hs;

    // Only the word-address field of the AXI addresses is decoded.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{s_axi_awaddr_i, s_axi_araddr_i};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            prio_rd_q <= 1'b0;
            is_wr_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rdata_q   <= '0;
            resp_q    <= '0;
            tmo_q     <= '0;
        end else begin
            state_q   <= state_d;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            prio_rd_q <= prio_rd_d;
            is_wr_q   <= is_wr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            rdata_q   <= rdata_d;
            resp_q    <= resp_d;
            tmo_q     <= tmo_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        prio_rd_d = prio_rd_q;
        is_wr_d   = is_wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        rdata_d   = rdata_q;
        resp_d    = resp_q;
        tmo_d     = tmo_q;
        rd_grant  = 1'b0;
        resp_hs   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // A half-accepted write blocks reads; otherwise a pending read
                // wins only when it has priority or no write is being offered.
                rd_grant = !aw_held_q && !w_held_q && s_axi_arvalid_i &&
                           (prio_rd_q || !(s_axi_awvalid_i || s_axi_wvalid_i));
                if (rd_grant) begin
                    addr_d  = s_axi_araddr_i[REG_AW+LSB-1:LSB];
                    is_wr_d = 1'b0;
                    tmo_d   = TMO_LOAD;
                    state_d = ST_ACCESS;
                end else begin
                    if (s_axi_awvalid_i && !aw_held_q) begin
                        aw_held_d = 1'b1;
                        addr_d    = s_axi_awaddr_i[REG_AW+LSB-1:LSB];
                    end
                    if (s_axi_wvalid_i && !w_held_q) begin
                        w_held_d = 1'b1;
                        wdata_d  = s_axi_wdata_i;
                        wstrb_d  = s_axi_wstrb_i;
                    end
                    if (aw_held_d && w_held_d) begin
                        is_wr_d = 1'b1;
                        tmo_d   = TMO_LOAD;
                        state_d = ST_ACCESS;
                    end
                end
            end

            ST_ACCESS: begin
                if (reg_ready_i) begin
                    resp_d = RESP_WIDTH'(resp_enc(reg_err_i, RESP_WIDTH));
                    if (!is_wr_q) begin
                        rdata_d = reg_err_i ? '0 : reg_rdata_i;
                    end
                    state_d = ST_RESP;
                end else if (tmo_q == '0) begin
                    resp_d = RESP_WIDTH'(resp_enc(1'b1, RESP_WIDTH));
                    if (!is_wr_q) begin
                        rdata_d = '0;
                    end
                    state_d = ST_RESP;
                end else begin
                    tmo_d = tmo_q - TW'(1);
                end
            end

            ST_RESP: begin
                resp_hs = is_wr_q ? s_axi_bready_i : s_axi_rready_i;
                if (resp_hs) begin
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                    prio_rd_d = is_wr_q;
                    state_d   = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // READY outputs are combinational; masking with rst_i keeps them low while reset is held.
    assign s_axi_awready_o = !rst_i && (state_q == ST_IDLE) && !aw_held_q && !rd_grant;
    assign s_axi_wready_o  = !rst_i && (state_q == ST_IDLE) && !w_held_q && !rd_grant;
    assign s_axi_arready_o = !rst_i && rd_grant;

    assign s_axi_bvalid_o  = (state_q == ST_RESP) && is_wr_q;
    assign s_axi_rvalid_o  = (state_q == ST_RESP) && !is_wr_q;
    assign s_axi_bresp_o   = resp_q;
    assign s_axi_rresp_o   = resp_q;
    assign s_axi_rdata_o   = rdata_q;

    assign reg_req_o   = (state_q == ST_ACCESS);
    assign reg_we_o    = (state_q == ST_ACCESS) && is_wr_q;
    assign reg_addr_o  = addr_q;
    assign reg_wdata_o = wdata_q;
    assign reg_wstrb_o = wstrb_q;

endmodule
